// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC arbiter: default sizing, FSM encoding and
// the tag that travels alongside each phase through the CORDIC pipeline.
package cordic_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int CORDIC_LAT_DEF = 18;
    localparam int TAG_IDX_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/cordic_rr_arb.sv
// Rotating-priority grant: the first asserted request at or after ptr_i
// (wrapping) wins; output is one-hot or zero.
module cordic_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PW-1:0]      gnt_idx_o
);

    logic          found_s;
    logic          hit_s;
    logic [PW-1:0] slot_s;

    // Walk the requesters in rotated order and latch onto the first hit.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        slot_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot_s         = PW'((int'(ptr_i) + k) % NUM_REQ);
            hit_s          = !found_s && req_i[slot_s];
            gnt_o[slot_s]  = gnt_o[slot_s] | hit_s;
            gnt_idx_o      = hit_s ? slot_s : gnt_idx_o;
            found_s        = found_s | hit_s;
        end
    end

endmodule

// File: rtl/cordic_arb.sv
// cordic_arb: shares one pipelined CORDIC among NUM_REQ requesters and routes
// each result back to its owner. Define CORDIC_ARB_PRIO_EN to give requester 0
// absolute priority (remaining requesters rotate among themselves).
module cordic_arb
    import cordic_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int CORDIC_LAT = CORDIC_LAT_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  arb_en,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*16-1:0] req_phase,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  cordic_en,
    output logic [15:0]           cordic_phase,
    input  logic signed [16:0]    cordic_sin,
    input  logic signed [16:0]    cordic_cos,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic signed [16:0]    rsp_sin,
    output logic signed [16:0]    rsp_cos,
    output logic                  busy,
    output logic                  drained
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e    state_q;
    logic          cordic_en_q;
    logic          drained_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    tag_t          tag_q [CORDIC_LAT];

    logic               grant_en_s;
    logic               accept_s;
    logic               busy_s;
    logic [NUM_REQ-1:0] rr_req_s;
    logic [NUM_REQ-1:0] rr_gnt_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [NUM_REQ-1:0] rsp_s;
    logic [PW-1:0]      rr_idx_s;
    logic [PW-1:0]      gnt_idx_s;
    logic [15:0]        phase_s;

    assign grant_en_s = (state_q == ST_RUN) && arb_en;

`ifdef CORDIC_ARB_PRIO_EN
    assign rr_req_s = req_valid & {{(NUM_REQ-1){grant_en_s}}, 1'b0};
`else
    assign rr_req_s = req_valid & {NUM_REQ{grant_en_s}};
`endif

    cordic_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_arb (
        .req_i     (rr_req_s),
        .ptr_i     (ptr_q),
        .gnt_o     (rr_gnt_s),
        .gnt_idx_o (rr_idx_s)
    );

    // Final grant and next pointer; the pointer only moves on a rotating grant.
    always_comb begin
        gnt_s     = rr_gnt_s;
        gnt_idx_s = rr_idx_s;
        ptr_d     = ptr_q;
`ifdef CORDIC_ARB_PRIO_EN
        if (grant_en_s && req_valid[0]) begin
            gnt_s     = NUM_REQ'(1);
            gnt_idx_s = '0;
        end else if (|rr_gnt_s) begin
            ptr_d = (rr_idx_s == PW'(NUM_REQ - 1)) ? '0 : rr_idx_s + PW'(1);
        end else begin
            ptr_d = ptr_q;
        end
`else
        if (|rr_gnt_s) begin
            ptr_d = (rr_idx_s == PW'(NUM_REQ - 1)) ? '0 : rr_idx_s + PW'(1);
        end else begin
            ptr_d = ptr_q;
        end
`endif
    end

    assign accept_s = |gnt_s;

    // Phase mux driven by the one-hot grant; zero when nothing is granted.
    always_comb begin
        phase_s = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            phase_s = phase_s | (gnt_s[i] ? req_phase[i*16 +: 16] : 16'h0000);
        end
    end

    // Control FSM; the drain waits for the tag pipe regardless of arb_en.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            cordic_en_q <= 1'b0;
            drained_q   <= 1'b0;
            ptr_q       <= '0;
        end else begin
            drained_q <= 1'b0;
            ptr_q     <= ptr_d;
            case (state_q)
                ST_IDLE: begin
                    if (arb_en) begin
                        state_q     <= ST_RUN;
                        cordic_en_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!arb_en) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!busy_s) begin
                        state_q     <= ST_IDLE;
                        cordic_en_q <= 1'b0;
                        drained_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cordic_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipe shifts in lockstep with the CORDIC, i.e. only while it is enabled.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int k = 0; k < CORDIC_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else if (cordic_en_q) begin
            tag_q[0].valid <= accept_s;
            tag_q[0].idx   <= TAG_IDX_W'(gnt_idx_s);
            for (int k = 1; k < CORDIC_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Occupancy and result-owner decode from the tag pipe.
    always_comb begin
        busy_s = 1'b0;
        for (int k = 0; k < CORDIC_LAT; k++) begin
            busy_s = busy_s | tag_q[k].valid;
        end
        rsp_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_s[i] = tag_q[CORDIC_LAT-1].valid && (tag_q[CORDIC_LAT-1].idx == TAG_IDX_W'(i));
        end
    end

    assign req_ready    = gnt_s;
    assign cordic_phase = phase_s;
    assign cordic_en    = cordic_en_q;
    assign drained      = drained_q;
    assign busy         = busy_s;
    assign rsp_valid    = rsp_s;
    assign rsp_sin      = cordic_sin;
    assign rsp_cos      = cordic_cos;

endmodule

// File: tb/tb_cordic_arb.sv
// Scoreboard bench for cordic_arb with a behavioural 18-stage CORDIC model.
module tb_cordic_arb;

    localparam int N   = 4;
    localparam int LAT = 18;

    logic                sys_clk = 1'b0;
    logic                sys_rst = 1'b0;
    logic                arb_en  = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [N*16-1:0]     req_phase = '0;
    logic [N-1:0]        req_ready;
    logic                cordic_en;
    logic [15:0]         cordic_phase;
    logic signed [16:0]  cordic_sin;
    logic signed [16:0]  cordic_cos;
    logic [N-1:0]        rsp_valid;
    logic signed [16:0]  rsp_sin;
    logic signed [16:0]  rsp_cos;
    logic                busy;
    logic                drained;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rsp_cnt = 0;

    typedef struct {
        int idx;
        int due;
        int s;
        int c;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [15:0] cp_q [LAT];

    cordic_arb #(.NUM_REQ(N), .CORDIC_LAT(LAT)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_phase    (req_phase),
        .req_ready    (req_ready),
        .cordic_en    (cordic_en),
        .cordic_phase (cordic_phase),
        .cordic_sin   (cordic_sin),
        .cordic_cos   (cordic_cos),
        .rsp_valid    (rsp_valid),
        .rsp_sin      (rsp_sin),
        .rsp_cos      (rsp_cos),
        .busy         (busy),
        .drained      (drained)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic int trig(input logic [15:0] ph, input bit use_cos);
        real a;
        real v;
        a = 6.283185307179586 * real'(ph) / 65536.0;
        v = 65535.0 * (use_cos ? $cos(a) : $sin(a));
        return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [15:0] phase_of(input int i);
        return 16'(16'h0800 + i * 16'h1A00);
    endfunction

    // Behavioural CORDIC: phase captured on an enabled edge, result after 17 more.
    always @(posedge sys_clk) begin
        if (cordic_en) begin
            cp_q[0] <= cordic_phase;
            for (int k = 1; k < LAT; k++) cp_q[k] <= cp_q[k-1];
        end
    end

    assign cordic_sin = 17'(trig(cp_q[LAT-1], 1'b0));
    assign cordic_cos = 17'(trig(cp_q[LAT-1], 1'b1));

    // Monitor: every result strobe is matched against the oldest expectation.
    always @(negedge sys_clk) begin
        if (rsp_valid != '0) begin
            rsp_cnt++;
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b at cycle %0d, required none", rsp_valid, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (rsp_valid != (N'(1) << mon_e.idx) || cyc != mon_e.due ||
                    iabs(int'(rsp_sin) - mon_e.s) > 16 || iabs(int'(rsp_cos) - mon_e.c) > 16) begin
                    n_fail++;
                    $display("FAIL rsp_match: got valid=%b cyc=%0d sin=%0d cos=%0d, required valid=%b cyc=%0d sin=%0d cos=%0d",
                             rsp_valid, cyc, rsp_sin, rsp_cos, N'(1) << mon_e.idx, mon_e.due, mon_e.s, mon_e.c);
                end
            end
        end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_missing: got no rsp_valid at cycle %0d, required owner %0d", cyc, sb_q[0].idx);
            void'(sb_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic push(input int idx, input logic [15:0] ph);
        sb_q.push_back('{idx, cyc + LAT - 1, trig(ph, 1'b0), trig(ph, 1'b1)});
    endtask

    task automatic apply_reset();
        sys_rst   = 1'b1;
        arb_en    = 1'b0;
        req_valid = '0;
        #2;
        sb_q.delete();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic restore_phases();
        for (int i = 0; i < N; i++) req_phase[i*16 +: 16] = phase_of(i);
    endtask

    initial begin
        int ng;
        int d_cnt;
        int base;
        bit seen;

        restore_phases();
        #1 sys_rst = 1'b1;
        #2;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_cordic_en", 32'(cordic_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_drained", 32'(drained), 32'h0);
        check("rst_phase", 32'(cordic_phase), 32'h0);
        tick();
        sys_rst = 1'b0;

        // Single request from requester 2 at a quarter turn.
        arb_en = 1'b1;
        tick();
        check("t1_cordic_en", 32'(cordic_en), 32'h1);
        req_phase[2*16 +: 16] = 16'h4000;
        req_valid = 4'b0100;
        #1;
        check("t1_grant", 32'(req_ready), 32'h4);
        check("t1_phase", 32'(cordic_phase), 32'h4000);
        tick();
        sb_q.push_back('{2, cyc + LAT - 1, 32'h0FFFF, 0});
        req_valid = '0;
        repeat (LAT + 4) tick();
        check("t1_done", 32'(sb_q.size()), 32'h0);
        restore_phases();

        // All four requesters held valid for 8 cycles.
        apply_reset();
        arb_en = 1'b1;
        tick();
        base = rsp_cnt;
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t2_grant", 32'(req_ready), 32'h1 << (i % 4));
            check("t2_phase", 32'(cordic_phase), 32'(phase_of(i % 4)));
            tick();
            push(i % 4, phase_of(i % 4));
        end
        req_valid = '0;
        repeat (LAT + 4) tick();
        check("t2_rsp_count", 32'(rsp_cnt - base), 32'd8);

        // Drain with 5 phases in flight.
        apply_reset();
        arb_en = 1'b1;
        tick();
        base = rsp_cnt;
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_grant", 32'(req_ready), 32'h2);
            tick();
            push(1, phase_of(1));
        end
        arb_en = 1'b0;
        #1;
        check("t3_ready_off", 32'(req_ready), 32'h0);
        ng = 0;
        d_cnt = 0;
        for (int i = 0; i < LAT + 8; i++) begin
            tick();
            if (req_ready != '0) ng++;
            if (drained) d_cnt++;
        end
        check("t3_no_grant", 32'(ng), 32'h0);
        check("t3_drained_once", 32'(d_cnt), 32'h1);
        check("t3_cordic_en_off", 32'(cordic_en), 32'h0);
        check("t3_busy_off", 32'(busy), 32'h0);
        check("t3_rsp_count", 32'(rsp_cnt - base), 32'd5);
        req_valid = '0;

        // Reset with 10 phases in flight.
        apply_reset();
        arb_en = 1'b1;
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t4_grant", 32'(req_ready), 32'h1 << (i % 4));
            tick();
            push(i % 4, phase_of(i % 4));
        end
        req_valid = '0;
        tick();
        tick();
        check("t4_busy_before", 32'(busy), 32'h1);
        sys_rst = 1'b1;
        #1;
        sb_q.delete();
        base = rsp_cnt;
        check("t4_busy_now", 32'(busy), 32'h0);
        check("t4_cordic_en_now", 32'(cordic_en), 32'h0);
        check("t4_rsp_now", 32'(rsp_valid), 32'h0);
        tick();
        sys_rst = 1'b0;
        arb_en  = 1'b0;
        repeat (LAT + 6) tick();
        check("t4_no_rsp", 32'(rsp_cnt - base), 32'h0);

        // Requesters 0 and 1 both held valid.
        apply_reset();
        arb_en = 1'b1;
        tick();
        req_valid = 4'b0011;
`ifdef CORDIC_ARB_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_prio_grant", 32'(req_ready), 32'h1);
            tick();
            push(0, phase_of(0));
        end
        req_valid = 4'b0010;
        #1;
        check("t5_prio_release", 32'(req_ready), 32'h2);
        tick();
        push(1, phase_of(1));
`else
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_rr_grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            push(i % 2, phase_of(i % 2));
        end
`endif
        req_valid = '0;
        repeat (LAT + 4) tick();
        check("t5_done", 32'(sb_q.size()), 32'h0);

        // arb_en toggles 1 -> 0 -> 1 while draining.
        apply_reset();
        arb_en = 1'b1;
        tick();
        req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_grant", 32'(req_ready), 32'h8);
            tick();
            push(3, phase_of(3));
        end
        arb_en = 1'b0;
        tick();
        tick();
        arb_en = 1'b1;
        tick();
        ng = 0;
        seen = 1'b0;
        for (int i = 0; i < LAT + 8 && !seen; i++) begin
            if (req_ready != '0) ng++;
            tick();
            if (drained) seen = 1'b1;
        end
        check("t6_drained_seen", 32'(seen), 32'h1);
        check("t6_no_grant_drain", 32'(ng), 32'h0);
        check("t6_idle_cordic_en", 32'(cordic_en), 32'h0);
        check("t6_idle_ready", 32'(req_ready), 32'h0);
        tick();
        check("t6_run_cordic_en", 32'(cordic_en), 32'h1);
        check("t6_run_ready", 32'(req_ready), 32'h8);
        tick();
        push(3, phase_of(3));
        req_valid = '0;
        arb_en = 1'b0;
        repeat (LAT + 6) tick();
        check("t6_done", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_arb.md
CORDIC_ARB -- requirements
Module: cordic_arb

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 4, number of requesters; CORDIC_LAT, default 18, clock edges from phase acceptance to result on the CORDIC outputs.
REQ-002 SHALL have port sys_clk, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port sys_rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port arb_en, input, 1, level enable for granting new requests.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester request.
REQ-006 SHALL have port req_phase, input, NUM_REQ*16, per-requester phase; requester i at bits [16i+15:16i]; full scale is 2^16 per 360 deg.
REQ-007 SHALL have port req_ready, output, NUM_REQ, one-hot-or-zero grant.
REQ-008 SHALL have port cordic_en, output, 1, drives the CORDIC enable.
REQ-009 SHALL have port cordic_phase, output, 16, drives the CORDIC phase input.
REQ-010 SHALL have ports cordic_sin and cordic_cos, input, 17 each, signed CORDIC results.
REQ-011 SHALL have port rsp_valid, output, NUM_REQ, one-hot result strobe naming the owning requester.
REQ-012 SHALL have ports rsp_sin and rsp_cos, output, 17 each, combinational pass-through of cordic_sin and cordic_cos.
REQ-013 SHALL have port busy, output, 1, high while any accepted phase is in flight.
REQ-014 SHALL have port drained, output, 1, single-cycle pulse on the DRAIN to IDLE transition.

Function
REQ-015 SHALL implement states IDLE, RUN and DRAIN.
REQ-016 SHALL transition IDLE to RUN when arb_en=1, RUN to DRAIN when arb_en=0, and DRAIN to IDLE when the tag pipe is empty; arb_en returning to 1 during DRAIN SHALL NOT abort the drain.
REQ-017 SHALL drive req_ready combinationally, nonzero only when state=RUN and arb_en=1, granting at most one requester with a valid request.
REQ-018 SHALL select the grant round-robin: search starts at pointer p, and p becomes (granted index + 1) mod NUM_REQ on each accept; p is unchanged when nothing is accepted.
REQ-019 SHALL treat an accept as req_valid[i] & req_ready[i] at a rising edge.
REQ-020 SHALL drive cordic_phase combinationally: the granted requester's phase, otherwise 16'h0000.
REQ-021 SHALL hold cordic_en=1 in RUN and DRAIN and cordic_en=0 in IDLE.
REQ-022 SHALL keep a CORDIC_LAT-deep tag pipe of {valid, requester index}, advancing only when cordic_en=1, so that tags stay aligned with the CORDIC pipeline.
REQ-023 SHALL assert rsp_valid[i] for exactly one cycle, in the cycle after the (CORDIC_LAT-1)th advancing edge following the accept edge, i.e. 18 cycles after accept at defaults.
REQ-024 SHALL produce results in acceptance order, with no response backpressure.
REQ-025 SHALL sustain one accept per cycle under continuous requests.
REQ-026 SHALL derive busy from the OR of all tag valid bits.

Reset
REQ-027 SHALL, on sys_rst, immediately force state=IDLE, p=0, all tag pipe entries to zero, rsp_valid=0, busy=0, drained=0, cordic_en=0, req_ready=0 and cordic_phase=0.
REQ-028 SHALL discard in-flight work on reset mid-operation, producing no rsp_valid for any phase accepted before reset.

Configuration
REQ-029 SHALL, when macro CORDIC_ARB_PRIO_EN is defined, give requester 0 absolute priority over the others, with requesters 1..NUM_REQ-1 round-robin among themselves.
REQ-030 SHALL, when CORDIC_ARB_PRIO_EN is undefined, apply pure round-robin over all requesters per REQ-018.

Structure
REQ-031 SHALL place the default NUM_REQ, CORDIC_LAT, the state encoding and the tag struct {valid, index} in shared package cordic_pkg.
REQ-032 SHALL implement the grant logic as sub-module cordic_rr_arb, taking request vector and pointer and returning a one-hot grant.

Verification
REQ-033 SHALL cover a single request: req 2 with phase 16'h4000 -> rsp_valid=4'b0100 exactly 18 cycles after accept, rsp_sin within 16 LSB of 17'h0FFFF, |rsp_cos| <= 16.
REQ-034 SHALL cover all four requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3, with 8 responses in the same order and consecutive cycles.
REQ-035 SHALL cover arb_en deasserted with 5 phases in flight -> no further grants, 5 responses, drained pulsed once, state IDLE, cordic_en=0.
REQ-036 SHALL cover sys_rst asserted for 1 cycle with 10 phases in flight -> zero responses afterwards, busy=0 immediately.
REQ-037 SHALL cover CORDIC_ARB_PRIO_EN defined with requesters 0 and 1 held valid -> only requester 0 is granted until it drops req_valid.
REQ-038 SHALL cover arb_en toggled 1 to 0 to 1 within DRAIN -> drain completes, drained pulses, then RUN resumes on the next cycle.
